// File: rtl/param_seq_alu_if.sv
// Bundles the request and result signals of the sequential ALU.
// The master side (switches/keys or a bench) drives the request,
// the slave side (the ALU) returns status and the result register.
interface param_seq_alu_if #(
   parameter int WIDTH = 4
) ();
   logic                   start;
   logic [2:0]             func;
   logic [WIDTH-1:0]       data;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     result;
   logic                   zero;

   modport master (
      output start, func, data,
      input  busy, done, result, zero
   );

   modport slave (
      input  start, func, data,
      output busy, done, result, zero
   );
endinterface

// File: rtl/param_seq_alu.sv
// Parametrised sequential ALU with a 2*WIDTH-bit result register.
// The low half of the result register is operand B of the next request,
// so chains of operations accumulate without extra storage.
// Single-cycle operations complete on the edge that accepts start;
// multiply runs as a shift-add loop over WIDTH further edges.
module param_seq_alu #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   param_seq_alu_if.slave   bus
);

   typedef enum logic {IDLE, MUL} stateType;

   localparam logic [WIDTH:0]   TwoWidth  = (WIDTH+1)'(2*WIDTH);
   localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH-1);
   localparam logic [CNT_W-1:0] CountOne  = CNT_W'(1);

   localparam logic [2:0] FuncInc  = 3'b000;
   localparam logic [2:0] FuncAdd  = 3'b001;
   localparam logic [2:0] FuncLog  = 3'b010;
   localparam logic [2:0] FuncOrR  = 3'b011;
   localparam logic [2:0] FuncShl  = 3'b100;
   localparam logic [2:0] FuncShr  = 3'b101;
   localparam logic [2:0] FuncMul  = 3'b110;
   localparam logic [2:0] FuncLoad = 3'b111;

   stateType               state, stateNext;
   logic [2*WIDTH-1:0]     result, resultNext;
   logic [2*WIDTH-1:0]     partial, partialNext;
   logic [2*WIDTH-1:0]     product;
   logic [WIDTH-1:0]       multiplicand, multiplicandNext;
   logic [WIDTH-1:0]       multiplier, multiplierNext;
   logic [CNT_W-1:0]       counter, counterNext;
   logic                   zero, zeroNext;
   logic                   done, doneNext;

   logic [WIDTH-1:0]       opA;
   logic [WIDTH-1:0]       opB;
   logic [2*WIDTH-1:0]     bExt;
   logic [2*WIDTH-1:0]     addend;
   logic [2*WIDTH-1:0]     opResult;

   assign opA    = bus.data;
   assign opB    = result[WIDTH-1:0];
   assign bExt   = {{WIDTH{1'b0}}, opB};
   assign addend = {{WIDTH{1'b0}}, multiplicand} << counter;

   assign bus.busy   = (state == MUL);
   assign bus.done   = done;
   assign bus.result = result;
   assign bus.zero   = zero;

   // Result of every single-cycle operation, computed from the live
   // data input and the current low half of the result register.
   // Shifts by 2*WIDTH or more clear the result outright.
   always_comb begin
      opResult = '0;
      case (bus.func)
         FuncInc:  opResult = (2*WIDTH)'({1'b0, opA} + (WIDTH+1)'(1));
         FuncAdd:  opResult = (2*WIDTH)'({1'b0, opA} + {1'b0, opB});
         FuncLog:  opResult = {opA | opB, opA ^ opB};
         FuncOrR:  opResult = (2*WIDTH)'(|(opA | opB));
         FuncShl:  opResult = ({1'b0, opA} >= TwoWidth) ? '0 : (bExt << opA);
         FuncShr:  opResult = ({1'b0, opA} >= TwoWidth) ? '0 : (bExt >> opA);
         FuncLoad: opResult = (2*WIDTH)'(opA);
         default:  opResult = '0;
      endcase
   end

   // Next-state and datapath control. In IDLE a start either finishes a
   // single-cycle op at once or launches the multiply loop. In MUL each
   // edge adds the shifted multiplicand when the current multiplier bit
   // is set; the last iteration writes the product and returns to IDLE.
   // Starts seen while in MUL, including on the finishing edge, are dropped.
   always_comb begin
      stateNext        = state;
      resultNext       = result;
      zeroNext         = zero;
      doneNext         = 1'b0;
      partialNext      = partial;
      multiplicandNext = multiplicand;
      multiplierNext   = multiplier;
      counterNext      = counter;
      product          = multiplier[0] ? (partial + addend) : partial;

      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.func == FuncMul) begin
                  stateNext        = MUL;
                  partialNext      = '0;
                  counterNext      = '0;
                  multiplicandNext = opA;
                  multiplierNext   = opB;
               end else begin
                  resultNext = opResult;
                  zeroNext   = (opResult == '0);
                  doneNext   = 1'b1;
               end
            end
         end
         MUL: begin
            partialNext    = product;
            multiplierNext = multiplier >> 1;
            counterNext    = counter + CountOne;
            if (counter == LastCount) begin
               stateNext   = IDLE;
               resultNext  = product;
               zeroNext    = (product == '0);
               doneNext    = 1'b1;
               counterNext = '0;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any multiply in flight
   // so none of its partial work reaches the result register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         result       <= '0;
         zero         <= 1'b1;
         done         <= 1'b0;
         partial      <= '0;
         multiplicand <= '0;
         multiplier   <= '0;
         counter      <= '0;
      end else begin
         state        <= stateNext;
         result       <= resultNext;
         zero         <= zeroNext;
         done         <= doneNext;
         partial      <= partialNext;
         multiplicand <= multiplicandNext;
         multiplier   <= multiplierNext;
         counter      <= counterNext;
      end
   end

endmodule

// File: tb/tb_param_seq_alu.sv
// Bench for the sequential ALU: a vector table of chained single-cycle
// operations, hand-written multiply sequences (holding, ignored starts,
// reset abort), a randomized run against an arithmetic reference model,
// and a WIDTH=8 instance for the wide multiply and carry cases.
module tb_param_seq_alu;

   logic clock;
   logic reset;

   param_seq_alu_if #(.WIDTH(4)) bus4 ();
   param_seq_alu_if #(.WIDTH(8)) bus8 ();

   param_seq_alu #(.WIDTH(4), .CNT_W(3)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   param_seq_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8)
   );

   typedef struct {
      logic [2:0] func;
      logic [3:0] data;
      logic [7:0] expResult;
      logic       expZero;
   } vecType;

   vecType vectors[16];
   int     assertCount = 0;
   int     failCount   = 0;

   // Free-running clock shared by both instances.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net in case a wait loop is ever broken.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present one request to the 4-bit instance for exactly one edge.
   task automatic applyStimulus(input logic [2:0] func, input logic [3:0] data);
      bus4.start = 1'b1;
      bus4.func  = func;
      bus4.data  = data;
      tick();
      bus4.start = 1'b0;
   endtask

   // Same for the 8-bit instance.
   task automatic applyStimulus8(input logic [2:0] func, input logic [7:0] data);
      bus8.start = 1'b1;
      bus8.func  = func;
      bus8.data  = data;
      tick();
      bus8.start = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("reset_result", 32'(bus4.result), 32'h0);
      checkOutput("reset_zero",   32'(bus4.zero),   32'h1);
      checkOutput("reset_busy",   32'(bus4.busy),   32'h0);
      checkOutput("reset_done",   32'(bus4.done),   32'h0);
   endtask

   // Reference model: plain arithmetic on the operation definitions.
   function automatic longint refOp(int w, int f, longint a, longint b);
      longint mask;
      mask = (longint'(1) << (2*w)) - 1;
      case (f)
         0: return a + 1;
         1: return a + b;
         2: return ((a | b) << w) | (a ^ b);
         3: return ((a | b) != 0) ? 1 : 0;
         4: return (a >= 2*w) ? 0 : ((b << a) & mask);
         5: return (a >= 2*w) ? 0 : (b >> a);
         6: return a * b;
         default: return a;
      endcase
   endfunction

   initial begin
      logic [7:0]  modelResult;
      logic [7:0]  held;
      logic [2:0]  f;
      logic [3:0]  d;
      longint      expected;
      int          latency;
      int          idle;

      vectors[0]  = '{3'b111, 4'hD, 8'h0D, 1'b0};
      vectors[1]  = '{3'b100, 4'h3, 8'h68, 1'b0};
      vectors[2]  = '{3'b101, 4'hF, 8'h00, 1'b1};
      vectors[3]  = '{3'b000, 4'hF, 8'h10, 1'b0};
      vectors[4]  = '{3'b001, 4'h7, 8'h07, 1'b0};
      vectors[5]  = '{3'b010, 4'h9, 8'hFE, 1'b0};
      vectors[6]  = '{3'b011, 4'h0, 8'h01, 1'b0};
      vectors[7]  = '{3'b111, 4'h0, 8'h00, 1'b1};
      vectors[8]  = '{3'b011, 4'h0, 8'h00, 1'b1};
      vectors[9]  = '{3'b111, 4'h5, 8'h05, 1'b0};
      vectors[10] = '{3'b101, 4'h2, 8'h01, 1'b0};
      vectors[11] = '{3'b111, 4'hF, 8'h0F, 1'b0};
      vectors[12] = '{3'b001, 4'hF, 8'h1E, 1'b0};
      vectors[13] = '{3'b100, 4'h7, 8'h00, 1'b1};
      vectors[14] = '{3'b111, 4'h3, 8'h03, 1'b0};
      vectors[15] = '{3'b100, 4'h5, 8'h60, 1'b0};

      reset = 1'b1;
      bus4.start = 1'b0; bus4.func = 3'b000; bus4.data = '0;
      bus8.start = 1'b0; bus8.func = 3'b000; bus8.data = '0;
      tick();
      doReset();

      // Increment with carry into bit WIDTH; busy never rises.
      applyStimulus(3'b000, 4'hF);
      checkOutput("inc_result", 32'(bus4.result), 32'h10);
      checkOutput("inc_zero",   32'(bus4.zero),   32'h0);
      checkOutput("inc_done",   32'(bus4.done),   32'h1);
      checkOutput("inc_busy",   32'(bus4.busy),   32'h0);
      tick();
      checkOutput("inc_done_drop", 32'(bus4.done), 32'h0);

      // Chained single-cycle vectors, back to back.
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vectors[i].func, vectors[i].data);
         checkOutput($sformatf("vec%0d_result", i), 32'(bus4.result), 32'(vectors[i].expResult));
         checkOutput($sformatf("vec%0d_zero", i),   32'(bus4.zero),   32'(vectors[i].expZero));
         checkOutput($sformatf("vec%0d_done", i),   32'(bus4.done),   32'h1);
         checkOutput($sformatf("vec%0d_busy", i),   32'(bus4.busy),   32'h0);
      end
      tick();
      checkOutput("vec_done_drop", 32'(bus4.done), 32'h0);

      // Multiply 0xD * 0xB: result held for four busy cycles, then 0x8F.
      doReset();
      applyStimulus(3'b111, 4'hD);
      applyStimulus(3'b110, 4'hB);
      for (int c = 1; c <= 3; c++) begin
         checkOutput($sformatf("mul_busy_c%0d", c),   32'(bus4.busy),   32'h1);
         checkOutput($sformatf("mul_hold_c%0d", c),   32'(bus4.result), 32'h0D);
         checkOutput($sformatf("mul_nodone_c%0d", c), 32'(bus4.done),   32'h0);
         tick();
      end
      checkOutput("mul_busy_c4", 32'(bus4.busy),   32'h1);
      checkOutput("mul_hold_c4", 32'(bus4.result), 32'h0D);
      tick();
      checkOutput("mul_result", 32'(bus4.result), 32'h8F);
      checkOutput("mul_zero",   32'(bus4.zero),   32'h0);
      checkOutput("mul_done",   32'(bus4.done),   32'h1);
      checkOutput("mul_busy",   32'(bus4.busy),   32'h0);
      tick();
      checkOutput("mul_done_drop", 32'(bus4.done), 32'h0);

      // Starts held high during a multiply are dropped; the first one
      // after done is taken, giving done on two consecutive cycles.
      doReset();
      applyStimulus(3'b111, 4'h3);
      applyStimulus(3'b110, 4'h5);
      bus4.start = 1'b1; bus4.func = 3'b000; bus4.data = 4'h0;
      for (int c = 1; c <= 3; c++) tick();
      checkOutput("ign_busy", 32'(bus4.busy),   32'h1);
      checkOutput("ign_hold", 32'(bus4.result), 32'h03);
      tick();
      checkOutput("ign_product", 32'(bus4.result), 32'h0F);
      checkOutput("ign_done",    32'(bus4.done),   32'h1);
      tick();
      bus4.start = 1'b0;
      checkOutput("ign_after_result", 32'(bus4.result), 32'h01);
      checkOutput("ign_after_done",   32'(bus4.done),   32'h1);
      tick();
      checkOutput("ign_after_drop", 32'(bus4.done), 32'h0);

      // Reset on the second busy cycle aborts the multiply.
      doReset();
      applyStimulus(3'b111, 4'h3);
      applyStimulus(3'b110, 4'h5);
      tick();
      checkOutput("abort_busy2", 32'(bus4.busy), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("abort_result", 32'(bus4.result), 32'h0);
      checkOutput("abort_zero",   32'(bus4.zero),   32'h1);
      checkOutput("abort_busy",   32'(bus4.busy),   32'h0);
      checkOutput("abort_done",   32'(bus4.done),   32'h0);
      for (int c = 0; c < 6; c++) begin
         tick();
         checkOutput($sformatf("abort_quiet%0d", c), 32'({bus4.done, bus4.busy, bus4.result}), 32'h0);
      end

      // Randomized requests checked against the arithmetic model.
      doReset();
      modelResult = 8'h00;
      for (int n = 0; n < 200; n++) begin
         idle = int'($urandom_range(0, 1));
         for (int k = 0; k < idle; k++) begin
            tick();
            checkOutput("rnd_idle_done", 32'(bus4.done), 32'h0);
         end
         f = 3'($urandom_range(0, 7));
         d = 4'($urandom_range(0, 15));
         expected = refOp(4, int'(f), longint'(d), longint'(modelResult[3:0]));
         held = modelResult;
         modelResult = 8'(expected);
         applyStimulus(f, d);
         if (f == 3'b110) begin
            latency = 0;
            for (int c = 1; c <= 12; c++) begin
               if (bus4.done) break;
               checkOutput("rnd_mul_hold", 32'(bus4.result), 32'(held));
               tick();
               latency = c;
            end
            checkOutput("rnd_mul_latency", 32'(latency), 32'd4);
         end
         checkOutput($sformatf("rnd%0d_result", n), 32'(bus4.result), 32'(modelResult));
         checkOutput($sformatf("rnd%0d_zero", n),   32'(bus4.zero),   32'(modelResult == 8'h00));
         checkOutput($sformatf("rnd%0d_done", n),   32'(bus4.done),   32'h1);
         checkOutput($sformatf("rnd%0d_busy", n),   32'(bus4.busy),   32'h0);
      end

      // Wide instance: 0xFF * 0xFF over eight busy cycles, and add carry.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("w8_reset_result", 32'(bus8.result), 32'h0);
      checkOutput("w8_reset_zero",   32'(bus8.zero),   32'h1);
      applyStimulus8(3'b111, 8'hFF);
      applyStimulus8(3'b110, 8'hFF);
      latency = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bus8.done) break;
         checkOutput("w8_mul_busy", 32'(bus8.busy),   32'h1);
         checkOutput("w8_mul_hold", 32'(bus8.result), 32'h00FF);
         tick();
         latency = c;
      end
      checkOutput("w8_mul_latency", 32'(latency),      32'd8);
      checkOutput("w8_mul_result",  32'(bus8.result),  32'hFE01);
      checkOutput("w8_mul_busy_lo", 32'(bus8.busy),    32'h0);
      applyStimulus8(3'b111, 8'hFF);
      applyStimulus8(3'b001, 8'h01);
      checkOutput("w8_add_result", 32'(bus8.result), 32'h0100);
      checkOutput("w8_add_zero",   32'(bus8.zero),   32'h0);
      checkOutput("w8_add_done",   32'(bus8.done),   32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
- Parametrised successor of the lab ALU-with-register datapath.
- Holds a 2*WIDTH-bit result register whose low WIDTH bits are operand B for the next operation.
- Adds a start/busy/done handshake, a registered zero flag, and a multi-cycle shift-add multiplier in place of a combinational one.
- Sits between board switch/key inputs and the LED/seven-segment display decode.

Parameters:
- WIDTH, 4, width of operand A and of operand B (result register is 2*WIDTH).
- CNT_W, 3, width of the multiply iteration counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request: sample func and data on this edge when idle.
- func  in  3  operation select.
- data  in  WIDTH  operand A.
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse when result/zero are updated by a completed operation.
- result  out  2*WIDTH  result register; result[WIDTH-1:0] is operand B.
- zero  out  1  registered, 1 when result == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: result=0, zero=1, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-multiply aborts the operation; nothing from it is written.
- Operand sampling: on an edge with start=1 and state=IDLE, latch A=data, B=result[WIDTH-1:0] and func.
- start is ignored while busy=1; no queueing.
- Single-cycle ops: result, zero and done=1 update on the same edge that samples start, so latency is 1 cycle.
- 000, A+1: result = zero-extended (WIDTH+1)-bit sum; carry lands in bit WIDTH.
- 001, A+B: same width rule as A+1.
- 010: result = {A|B, A^B}.
- 011: result = {0, |(A|B)}.
- 100: result = ({W zeros, B} << A); bits beyond 2*WIDTH are lost; A >= 2*WIDTH gives 0.
- 101: result = ({W zeros, B} >> A), logical shift; A >= 2*WIDTH gives 0.
- 111, load: result = {0, A}.
- 110, multiply (A*B unsigned, multi-cycle):
  - State machine is IDLE -> MUL -> IDLE.
  - Start edge (edge 0): enter MUL, busy=1, clear partial product, counter=0, latch multiplicand and multiplier.
  - Each MUL edge: if the current multiplier bit is 1, add (multiplicand << counter) to the partial product; counter++.
  - On the edge where counter == WIDTH-1: write the final product to result, update zero, done=1, busy=0, return to IDLE.
  - Total latency is WIDTH edges after the start edge.
  - result holds its old value throughout MUL.
- done is high for exactly one cycle per completed op and is low on all other cycles.
- busy and done are never high together.
- A start arriving on the same edge that done rises (i.e. while state is MUL) is ignored.
- A start in the cycle after done is accepted; back-to-back single-cycle ops give done high on consecutive cycles.
- zero is always consistent with result; it changes only on the edges where result changes.
- No X propagation: func values outside the list cannot occur (3-bit field fully decoded).

Test Plan:
- Reset, then start func=000 data=4'hF -> next cycle result=8'h10, zero=0, done pulse 1 cycle, busy stays 0.
- Reset; func=111 data=4'hD (result=8'h0D); then func=110 data=4'hB -> busy high 4 cycles, result stays 8'h0D during busy, then result=8'h8F, done=1 for 1 cycle.
- With result=8'h0D: func=100 data=4'h3 -> result=8'h68. Then from 8'h68 (B=4'h8): func=101 data=4'hF -> result=8'h00, zero=1.
- During a multiply, pulse start with func=000 every cycle -> ignored; final product unchanged; the first start after done is accepted.
- Assert reset on the 2nd busy cycle of a multiply -> next cycle result=0, zero=1, busy=0, done=0, no done pulse afterwards.
- Rerun with WIDTH=8, CNT_W=4: load 8'hFF, multiply by 8'hFF -> after 8 busy cycles result=16'hFE01. Also load 8'hFF then func=001 data=8'h01 -> result=16'h0100.
